// File: rtl/mul_seq_24bit.sv
// Sequential shift-add multiplier: one partial-product step per clock over operand
// magnitudes, with the sign applied to the full product on the final step.
module mul_seq_24bit #(
   parameter int WIDTH = 24
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state, next_state;
   logic [WIDTH-1:0]     opa, opb;
   logic                 sgn;
   logic [2*WIDTH-1:0]   acc, acc_next, prod;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     mag_a, mag_b, addend;
   logic [WIDTH:0]       sum;
   logic                 neg, last;

   // Unsigned negate of the most negative value yields 2^(WIDTH-1), which still
   // fits as an unsigned WIDTH-bit magnitude.
   assign mag_a = (sgn && opa[WIDTH-1]) ? -opa : opa;
   assign mag_b = (sgn && opb[WIDTH-1]) ? -opb : opb;
   assign neg   = sgn && (opa[WIDTH-1] ^ opb[WIDTH-1]);
   assign last  = (cnt == CW'(WIDTH - 1));

   // Right-shifting accumulator: add into the upper half, then shift the pair down.
   assign addend   = mag_b[cnt] ? mag_a : '0;
   assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
   assign acc_next = {sum, acc[WIDTH-1:1]};
   assign prod     = neg ? -acc_next : acc_next;

   assign Busy = (state == RUN);
   assign Done = (state == DONE);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (Start) next_state = RUN;
         RUN:     if (last)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         opa      <= '0;
         opb      <= '0;
         sgn      <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         ResultLo <= '0;
         ResultHi <= '0;
      end else if (state == IDLE && Start) begin
         opa <= OpA;
         opb <= OpB;
         sgn <= Signed;
         acc <= '0;
         cnt <= '0;
      end else if (state == RUN) begin
         acc <= acc_next;
         if (last) {ResultHi, ResultLo} <= prod;
         else      cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mul_seq_24bit.sv
// Directed bench for mul_seq_24bit: vector table plus hand-written sequences for
// start re-pulse, mid-run reset and back-to-back operation.
module tb_mul_seq_24bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [23:0] opa, opb;
   logic        busy, done;
   logic [23:0] res_lo, res_hi;

   int n_cmp = 0;
   int n_bad = 0;

   mul_seq_24bit #(.WIDTH(24)) dut (
      .Clock(clk), .Reset(rst), .Start(start), .Signed(sgn),
      .OpA(opa), .OpB(opb), .Busy(busy), .Done(done),
      .ResultLo(res_lo), .ResultHi(res_hi)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [23:0] a, b;
      logic [23:0] hi, lo;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a multiply (caller sits 1ns after an edge); returns product and latency.
   task automatic run_mul(input logic s, input logic [23:0] a, input logic [23:0] b,
                          output logic [47:0] prod, output int lat);
      logic busy_ok;
      sgn = s; opa = a; opb = b; start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", {47'd0, busy}, 48'd1);
      busy_ok = 1'b1;
      lat = -1;
      prod = '0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done) begin
            lat = i;
            prod = {res_hi, res_lo};
            chk("busy_low_in_done", {47'd0, busy}, 48'd0);
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
      chk("busy_held_in_run", {47'd0, busy_ok}, 48'd1);
      tick();
      chk("done_one_cycle", {46'd0, done, busy}, 48'd0);
   endtask

   initial begin
      logic [47:0] p, held;
      int          lat, ndone;
      int          t [$];

      vecs[0]  = '{1'b0, 24'h000003, 24'h000005, 24'h000000, 24'h00000F};
      vecs[1]  = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 24'h000001};
      vecs[2]  = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000001};
      vecs[3]  = '{1'b1, 24'hFFFFFE, 24'h000003, 24'hFFFFFF, 24'hFFFFFA};
      vecs[4]  = '{1'b1, 24'h800000, 24'h800000, 24'h400000, 24'h000000};
      vecs[5]  = '{1'b0, 24'h800000, 24'h000002, 24'h000001, 24'h000000};
      vecs[6]  = '{1'b0, 24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};
      vecs[7]  = '{1'b1, 24'h000005, 24'hFFFFFD, 24'hFFFFFF, 24'hFFFFF1};
      vecs[8]  = '{1'b0, 24'h123456, 24'h000010, 24'h000001, 24'h234560};
      vecs[9]  = '{1'b1, 24'h7FFFFF, 24'h800000, 24'hC00000, 24'h800000};
      vecs[10] = '{1'b0, 24'hABCDEF, 24'h000001, 24'h000000, 24'hABCDEF};

      // Reset with Start asserted: nothing may begin.
      rst = 1'b1; start = 1'b1; sgn = 1'b0; opa = 24'd9; opb = 24'd9;
      tick(); tick();
      chk("reset_state", {res_hi, res_lo}, 48'd0);
      chk("reset_busy_done", {46'd0, busy, done}, 48'd0);
      start = 1'b0;
      rst = 1'b0;
      tick();

      foreach (vecs[i]) begin
         run_mul(vecs[i].s, vecs[i].a, vecs[i].b, p, lat);
         chk($sformatf("vec%0d_latency", i), 48'(lat), 48'd24);
         chk($sformatf("vec%0d_product", i), p, {vecs[i].hi, vecs[i].lo});
      end

      // Result holds through IDLE, ignoring input changes.
      opa = 24'h111111; opb = 24'h222222;
      repeat (5) tick();
      chk("result_hold_idle", {res_hi, res_lo}, 48'h000000ABCDEF);

      // Start re-pulsed with 7x7 during RUN of 2x2.
      sgn = 1'b0; opa = 24'd2; opb = 24'd2; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      opa = 24'd7; opb = 24'd7; start = 1'b1;
      repeat (4) tick();
      start = 1'b0;
      ndone = 0; held = '0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin ndone++; held = {res_hi, res_lo}; end
         tick();
      end
      chk("repulse_done_count", 48'(ndone), 48'd1);
      chk("repulse_result", held, 48'd4);

      // Reset at RUN step 10 aborts with no Done.
      opa = 24'd9; opb = 24'd9; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      #1;
      chk("midrun_reset_flags", {46'd0, busy, done}, 48'd0);
      chk("midrun_reset_result", {res_hi, res_lo}, 48'd0);
      tick();
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done || busy) ndone++;
      end
      chk("no_activity_after_abort", 48'(ndone), 48'd0);
      run_mul(1'b0, 24'd4, 24'd4, p, lat);
      chk("post_reset_latency", 48'(lat), 48'd24);
      chk("post_reset_product", p, 48'h10);

      // Start held high: Done every 26 cycles.
      opa = 24'd3; opb = 24'd3; start = 1'b1;
      for (int c = 0; c < 90; c++) begin
         tick();
         if (done) t.push_back(c);
      end
      start = 1'b0;
      chk("b2b_done_count", 48'(t.size()), 48'd3);
      if (t.size() >= 3) begin
         chk("b2b_gap1", 48'(t[1] - t[0]), 48'd26);
         chk("b2b_gap2", 48'(t[2] - t[1]), 48'd26);
      end else begin
         chk("b2b_gaps_missing", 48'(t.size()), 48'd3);
      end
      chk("b2b_result", {res_hi, res_lo}, 48'd9);
      repeat (30) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
